// File: rtl/div_ctrl_pkg.sv
// rtl/div_ctrl_pkg.sv - shared state encoding and divider handshake constants
package div_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DONE  = 2'd2,
    S_DRAIN = 2'd3
  } div_state_e;

  localparam logic DIVSTART       = 1'b1;
  localparam logic DIVSTOP        = 1'b0;
  localparam logic DIVRESULTREADY = 1'b1;

endpackage

// File: rtl/div_ctrl_if.sv
// rtl/div_ctrl_if.sv - EX-stage request, divider handshake and HI/LO write bundle
interface div_ctrl_if;
  logic        div_req_i;
  logic        signed_i;
  logic [31:0] rs_i;
  logic [31:0] rt_i;
  logic        flush_i;
  logic        stall_i;
  logic [63:0] div_result_i;
  logic        div_ready_i;
  logic        div_start_o;
  logic        div_annul_o;
  logic        div_signed_o;
  logic [31:0] div_op1_o;
  logic [31:0] div_op2_o;
  logic        stall_req_o;
  logic        whilo_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  // slave: the controller; master: EX stage plus divider environment
  modport slave (
    input  div_req_i, signed_i, rs_i, rt_i, flush_i, stall_i, div_result_i, div_ready_i,
    output div_start_o, div_annul_o, div_signed_o, div_op1_o, div_op2_o,
           stall_req_o, whilo_o, hi_o, lo_o
  );

  modport master (
    output div_req_i, signed_i, rs_i, rt_i, flush_i, stall_i, div_result_i, div_ready_i,
    input  div_start_o, div_annul_o, div_signed_o, div_op1_o, div_op2_o,
           stall_req_o, whilo_o, hi_o, lo_o
  );
endinterface

// File: rtl/div_ctrl.sv
// rtl/div_ctrl.sv - EX-stage controller for the multi-cycle DIV/DIVU path
module div_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int DRAIN_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  div_ctrl_if.slave  dif
);

  localparam int CW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  div_state_e  r_state;
  div_state_e  w_next;
  logic        r_signed;
  logic [31:0] r_op1;
  logic [31:0] r_op2;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [CW-1:0] r_drain_cnt;

  logic w_accept;
  logic w_capture;
  logic w_start;
  logic w_annul;
  logic w_stall_req;
  logic w_whilo;
  logic w_drain_last;

  assign w_accept     = (r_state == S_IDLE) && dif.div_req_i && !dif.flush_i;
  assign w_capture    = (r_state == S_RUN) && (dif.div_ready_i == DIVRESULTREADY) && !dif.flush_i;
  assign w_drain_last = (r_drain_cnt == CW'(DRAIN_CYCLES - 1));

  always_comb begin
    w_next      = r_state;
    w_start     = DIVSTOP;
    w_annul     = 1'b0;
    w_stall_req = 1'b0;
    w_whilo     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_stall_req = 1'b1;
          w_next      = S_RUN;
        end
      end
      S_RUN: begin
        w_stall_req = (dif.div_ready_i != DIVRESULTREADY);
        // flush beats a coincident ready: the result is dropped
        if (dif.flush_i) begin
          w_annul = 1'b1;
          w_next  = S_DRAIN;
        end else begin
          w_start = DIVSTART;
          if (dif.div_ready_i == DIVRESULTREADY) w_next = S_DONE;
        end
      end
      S_DONE: begin
        w_whilo = !dif.flush_i;
        if (dif.flush_i || !dif.stall_i) w_next = S_IDLE;
      end
      S_DRAIN: begin
        if (w_drain_last) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_signed    <= 1'b0;
      r_op1       <= '0;
      r_op2       <= '0;
      r_hi        <= '0;
      r_lo        <= '0;
      r_drain_cnt <= '0;
    end else begin
      r_state <= w_next;
      // operands stay frozen for the whole divide; the divider re-reads signs at fix-up
      if (w_accept) begin
        r_signed <= dif.signed_i;
        r_op1    <= dif.rs_i;
        r_op2    <= dif.rt_i;
      end
      if (w_capture) begin
        r_hi <= dif.div_result_i[63:32];
        r_lo <= dif.div_result_i[31:0];
      end
      if (r_state == S_DRAIN) r_drain_cnt <= r_drain_cnt + 1'b1;
      else                    r_drain_cnt <= '0;
    end
  end

  assign dif.div_start_o  = w_start;
  assign dif.div_annul_o  = w_annul;
  assign dif.div_signed_o = r_signed;
  assign dif.div_op1_o    = r_op1;
  assign dif.div_op2_o    = r_op2;
  assign dif.stall_req_o  = w_stall_req;
  assign dif.whilo_o      = w_whilo;
  assign dif.hi_o         = r_hi;
  assign dif.lo_o         = r_lo;

endmodule
